// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and frame geometry common to RX and TX.
// No logic of its own; types and constants only.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, RECV} state_t;

  localparam int BAUD_DIV_DEFAULT = 109;
  localparam int DATA_BITS        = 8;
  localparam int FRAME_BITS       = 10;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous input; reset value chosen per use.
// Latency 2 clocks; no handshake.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes RX, samples mid-bit, presents a byte with rdy and frm_err.
// Latency: rdy 1036 clocks after the start edge at BAUD_DIV=109; rdy held until clr_rdy or next start.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  input  logic                 clr_rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rdy,
  output logic                 frm_err
);

  localparam int CW       = $clog2(BAUD_DIV);
  localparam int HALF     = BAUD_DIV / 2;
  localparam int STOP_IDX = FRAME_BITS - 2;

  state_t              state, state_nxt;
  logic                rx_s, rx_q;
  logic                start_edge;
  logic [CW-1:0]       baud_cnt;
  logic [3:0]          bit_cnt;
  logic [DATA_BITS:0]  shreg;
  logic                strobe, start_det, sample_bit, frame_done;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (RX),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_q <= 1'b1;
    else        rx_q <= rx_s;
  end

  assign start_edge = rx_q & ~rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    strobe     = (state != IDLE) && (baud_cnt == '0);
    start_det  = 1'b0;
    sample_bit = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          start_det = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        // A line that is high again at mid-start was a glitch, not a frame.
        if (strobe) state_nxt = rx_s ? IDLE : RECV;
      end
      RECV: begin
        if (strobe) begin
          if (bit_cnt == 4'(STOP_IDX)) begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
          end else begin
            sample_bit = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else if (start_det) begin
      baud_cnt <= CW'(HALF);
      bit_cnt  <= '0;
    end else if (state != IDLE) begin
      baud_cnt <= strobe ? CW'(BAUD_DIV - 1) : baud_cnt - 1'b1;
      if (sample_bit || frame_done) bit_cnt <= bit_cnt + 4'd1;
      if (sample_bit) shreg <= {rx_s, shreg[DATA_BITS:1]};
    end
  end

  // Completion outranks clr_rdy so a byte landing in the acknowledge cycle is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data <= '0;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
    end else if (frame_done) begin
      rx_data <= shreg[DATA_BITS:1];
      rdy     <= 1'b1;
      frm_err <= ~rx_s;
    end else begin
      if (start_det || clr_rdy) rdy <= 1'b0;
      if (start_det)            frm_err <= 1'b0;
    end
  end

endmodule
